ex_mem_skid_reg: RTL and testbench

Parametrised EX→MEM pipeline-stage register with a two-entry skid buffer and a valid/ready handshake. It replaces the fixed-field, stall-only stage register. The stage carries an opaque data payload and a separately squashable control bundle (RegWrite, MemToReg, MemRead, MemWrite, …), and supports flush and backpressure. A registered `in_ready_o` breaks the combinational stall path from MEM back into EX. A saturating counter reports backpressure cycles to the performance monitor.

---
 rtl/ex_mem_skid_reg.sv | 143 ++++++++++++++
 tb/tb_ex_mem_skid_reg.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline-stage register with a two-entry skid buffer, valid/ready handshake,
// flush, squashable control bundle and a saturating backpressure counter.
module ex_mem_skid_reg #(
   parameter int DATA_W = 170,
   parameter int CTRL_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [1:0]        occupancy_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   input  logic              stall_clr_i
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [DATA_W-1:0] m_data_q;
   logic [CTRL_W-1:0] m_ctrl_q;
   logic [DATA_W-1:0] s_data_q;
   logic [CTRL_W-1:0] s_ctrl_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic [1:0]        occ_q;
   logic [1:0]        occ_d;
   logic [CNT_W-1:0]  stall_cnt_q;
   logic              in_fire;
   logic              out_fire;
   logic              load_m_in;
   logic              load_m_skid;
   logic              load_s;

   assign in_fire  = in_valid_i & in_ready_q;
   assign out_fire = out_valid_q & out_ready_i;

   always_comb begin
      state_d     = state_q;
      load_m_in   = 1'b0;
      load_m_skid = 1'b0;
      load_s      = 1'b0;
      occ_d       = 2'd0;
      if (flush_i) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d   = ST_FULL;
                  load_m_in = 1'b1;
               end
            end
            ST_FULL: begin
               if (in_fire && out_fire) begin
                  load_m_in = 1'b1;
               end else if (in_fire) begin
                  state_d = ST_SKID;
                  load_s  = 1'b1;
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_SKID: begin
               if (out_fire) begin
                  state_d     = ST_FULL;
                  load_m_skid = 1'b1;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      case (state_d)
         ST_FULL: occ_d = 2'd1;
         ST_SKID: occ_d = 2'd2;
         default: occ_d = 2'd0;
      endcase
   end

   // Handshake flags and control are precomputed from the next state so every
   // output leaves straight from a flop; control is squashed on entry to EMPTY.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_EMPTY;
         m_data_q    <= '0;
         m_ctrl_q    <= '0;
         s_data_q    <= '0;
         s_ctrl_q    <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         occ_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= (state_d != ST_SKID);
         out_valid_q <= (state_d != ST_EMPTY);
         occ_q       <= occ_d;
         if (load_m_in) begin
            m_data_q <= in_data_i;
         end else if (load_m_skid) begin
            m_data_q <= s_data_q;
         end
         if (state_d == ST_EMPTY) begin
            m_ctrl_q <= '0;
         end else if (load_m_in) begin
            m_ctrl_q <= in_ctrl_i;
         end else if (load_m_skid) begin
            m_ctrl_q <= s_ctrl_q;
         end
         if (load_s) begin
            s_data_q <= in_data_i;
            s_ctrl_q <= in_ctrl_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || stall_clr_i) begin
         stall_cnt_q <= '0;
      end else if (out_valid_q && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = m_data_q;
   assign out_ctrl_o  = m_ctrl_q;
   assign occupancy_o = occ_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Self-checking bench for ex_mem_skid_reg: directed scenarios plus random stress
// against a queue-based reference model of the stage.
module tb_ex_mem_skid_reg;

   localparam int DW = 170;
   localparam int CW = 4;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } entry_t;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, out_ready, stall_clr;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          in_ready, out_valid;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic [1:0]    occupancy;
   logic [15:0]   stall_cnt;
   logic          sm_in_ready, sm_out_valid;
   logic [DW-1:0] sm_out_data;
   logic [CW-1:0] sm_out_ctrl;
   logic [1:0]    sm_occupancy;
   logic [2:0]    sm_stall_cnt;

   int total = 0;
   int bad   = 0;

   entry_t        mq[$];
   logic [DW-1:0] m_shown = '0;
   int            m_cnt   = 0;
   int            m_cnt_s = 0;

   always #5 clk = ~clk;

   ex_mem_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) u_dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
      .in_ready_o(in_ready), .in_data_i(in_data), .in_ctrl_i(in_ctrl),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .out_ctrl_o(out_ctrl), .occupancy_o(occupancy), .stall_cnt_o(stall_cnt),
      .stall_clr_i(stall_clr)
   );

   ex_mem_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(3)) u_dut_small (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
      .in_ready_o(sm_in_ready), .in_data_i(in_data), .in_ctrl_i(in_ctrl),
      .out_valid_o(sm_out_valid), .out_ready_i(out_ready), .out_data_o(sm_out_data),
      .out_ctrl_o(sm_out_ctrl), .occupancy_o(sm_occupancy), .stall_cnt_o(sm_stall_cnt),
      .stall_clr_i(stall_clr)
   );

   task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model with the pre-edge handshake, compare.
   task automatic applyStimulus(input logic r, input logic f, input logic iv,
                                input logic [DW-1:0] d, input logic [CW-1:0] c,
                                input logic ordy, input logic clr);
      logic   m_ready, m_valid, ifire, ofire;
      entry_t e;
      rst = r; flush = f; in_valid = iv; in_data = d; in_ctrl = c;
      out_ready = ordy; stall_clr = clr;
      m_ready = (mq.size() < 2);
      m_valid = (mq.size() > 0);
      ifire   = iv & m_ready;
      ofire   = m_valid & ordy;
      @(posedge clk);
      #1;
      if (r || clr) begin
         m_cnt = 0; m_cnt_s = 0;
      end else if (m_valid && !ordy) begin
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt_s < 7) m_cnt_s++;
      end
      if (r) begin
         mq.delete();
         m_shown = '0;
      end else if (f) begin
         mq.delete();
      end else begin
         if (ofire) void'(mq.pop_front());
         if (ifire) begin
            e.d = d; e.c = c;
            mq.push_back(e);
         end
      end
      if (mq.size() > 0) m_shown = mq[0].d;
      checkOutput("in_ready",  256'(in_ready),  256'(mq.size() < 2));
      checkOutput("out_valid", 256'(out_valid), 256'(mq.size() > 0));
      checkOutput("out_data",  256'(out_data),  256'(m_shown));
      checkOutput("out_ctrl",  256'(out_ctrl),  (mq.size() > 0) ? 256'(mq[0].c) : 256'(0));
      checkOutput("occupancy", 256'(occupancy), 256'(mq.size()));
      checkOutput("stall_cnt", 256'(stall_cnt), 256'(m_cnt));
      checkOutput("stall_cnt_w3", 256'(sm_stall_cnt), 256'(m_cnt_s));
   endtask

   function automatic logic [DW-1:0] rndData();
      logic [191:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return t[DW-1:0];
   endfunction

   initial begin
      logic [DW-1:0] z;
      z = '0;
      applyStimulus(1, 0, 0, z, 4'h0, 0, 0);
      applyStimulus(1, 0, 0, z, 4'h0, 0, 0);
      checkOutput("reset_ready", 256'(in_ready), 256'(1));
      checkOutput("reset_data",  256'(out_data), 256'(0));

      // Streaming 1..8 with ctrl A
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(0, 0, 1, DW'(i), 4'hA, 1, 0);
         checkOutput("stream_data", 256'(out_data), 256'(i));
         checkOutput("stream_occ",  256'(occupancy), 256'(1));
      end
      applyStimulus(0, 0, 0, z, 4'h0, 1, 0);
      checkOutput("stream_drain_occ", 256'(occupancy), 256'(0));

      // Skid: FULL with 5, drop ready while offering 6
      applyStimulus(0, 0, 1, DW'(5), 4'h3, 0, 0);
      applyStimulus(0, 0, 1, DW'(6), 4'h3, 0, 0);
      checkOutput("skid_occ",   256'(occupancy), 256'(2));
      checkOutput("skid_ready", 256'(in_ready),  256'(0));
      checkOutput("skid_data",  256'(out_data),  256'(5));
      applyStimulus(0, 0, 1, DW'(99), 4'h3, 1, 0);
      checkOutput("skid_rec_data", 256'(out_data), 256'(6));
      checkOutput("skid_rec_occ",  256'(occupancy), 256'(1));
      applyStimulus(0, 0, 0, z, 4'h0, 1, 0);
      checkOutput("skid_empty_occ", 256'(occupancy), 256'(0));

      // Flush from SKID holding 7,8 with 9 offered
      applyStimulus(0, 0, 1, DW'(7), 4'h5, 0, 0);
      applyStimulus(0, 0, 1, DW'(8), 4'h5, 0, 0);
      applyStimulus(0, 1, 1, DW'(9), 4'h5, 0, 0);
      checkOutput("flush_valid", 256'(out_valid), 256'(0));
      checkOutput("flush_ctrl",  256'(out_ctrl),  256'(0));
      checkOutput("flush_ready", 256'(in_ready),  256'(1));
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, z, 4'h0, 1, 0);

      // Reset while FULL with ctrl F
      applyStimulus(0, 0, 1, DW'(123), 4'hF, 0, 0);
      applyStimulus(1, 0, 0, z, 4'h0, 0, 0);
      checkOutput("rst_mid_ctrl", 256'(out_ctrl), 256'(0));
      checkOutput("rst_mid_data", 256'(out_data), 256'(0));

      // Stall counter: 10 cycles, then 2 more (3-bit copy saturates), then clear
      applyStimulus(0, 0, 1, DW'(44), 4'h1, 0, 0);
      for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, z, 4'h0, 0, 0);
      checkOutput("cnt_10", 256'(stall_cnt), 256'(10));
      applyStimulus(0, 0, 0, z, 4'h0, 0, 0);
      applyStimulus(0, 0, 0, z, 4'h0, 0, 0);
      checkOutput("cnt_12",    256'(stall_cnt),    256'(12));
      checkOutput("cnt_w3_sat", 256'(sm_stall_cnt), 256'(7));
      applyStimulus(0, 0, 0, z, 4'h0, 0, 1);
      checkOutput("cnt_clr", 256'(stall_cnt), 256'(0));
      applyStimulus(0, 1, 0, z, 4'h0, 1, 0);

      // Random stress
      for (int i = 0; i < 10000; i++) begin
         applyStimulus(($urandom_range(999) == 0), ($urandom_range(49) == 0),
                       1'($urandom), rndData(), 4'($urandom),
                       ($urandom_range(99) < 60), ($urandom_range(99) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
